// File: rtl/sram_bg_loader_if.sv
// Byte-stream input and SRAM write-port bundle for the background loader.
// Latency: none, wires only.
// Backpressure: o_byte_ready gates i_byte_valid; a byte moves only when both are high.
interface sram_bg_loader_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16
);
    logic [7:0]            i_byte;
    logic                  i_byte_valid;
    logic                  o_byte_ready;
    logic                  o_sram_writing;
    logic                  o_sram_we_n;
    logic [ADDR_WIDTH-1:0] o_sram_addr;
    logic [DATA_WIDTH-1:0] o_sram_data;

    modport master (
        input  i_byte, i_byte_valid,
        output o_byte_ready, o_sram_writing, o_sram_we_n, o_sram_addr, o_sram_data
    );

    modport slave (
        output i_byte, i_byte_valid,
        input  o_byte_ready, o_sram_writing, o_sram_we_n, o_sram_addr, o_sram_data
    );
endinterface

// File: rtl/sram_bg_loader.sv
// Streams little-endian byte pairs into SRAM words 0..WORD_COUNT-1; optional trailing checksum (CHECKSUM_EN).
// Latency: one word per 5+WE_CYCLES-1 cycles with back-to-back bytes; DONE one cycle after the last write.
// Backpressure: o_byte_ready is registered and high only while waiting for a byte; idle bytes are held, never dropped.
module sram_bg_loader #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int WORD_COUNT = 307200,
    parameter int WE_CYCLES  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    sram_bg_loader_if.master  bus,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);
    localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_COUNT - 1);
    localparam logic [CNT_W-1:0]      LAST_WE   = CNT_W'(WE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RECV_LO, S_RECV_HI, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
`ifdef CHECKSUM_EN
        , S_CHK_LO, S_CHK_HI
`endif
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_byte_ready;
    logic                  r_writing;
    logic                  r_we_n;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CNT_W-1:0]      r_we_cnt;
    logic                  w_xfer;
    logic                  w_start;
    logic                  w_nxt_rdy;
`ifdef CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_sum;
    logic [7:0]            r_chk_lo;
    logic                  r_error;
`endif

    // Ready only ever rises in receive states, so a transfer implies one of them.
    assign w_xfer  = bus.i_byte_valid && r_byte_ready;
    assign w_start = i_start && (r_state == S_IDLE || r_state == S_DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_start) w_state_nxt = S_RECV_LO;
            S_RECV_LO:  if (w_xfer) w_state_nxt = S_RECV_HI;
            S_RECV_HI:  if (w_xfer) w_state_nxt = S_WR_SETUP;
            S_WR_SETUP: w_state_nxt = S_WR_PULSE;
            S_WR_PULSE: if (r_we_cnt == LAST_WE) w_state_nxt = S_WR_HOLD;
            S_WR_HOLD: begin
                if (r_addr != LAST_ADDR) w_state_nxt = S_RECV_LO;
`ifdef CHECKSUM_EN
                else                     w_state_nxt = S_CHK_LO;
`else
                else                     w_state_nxt = S_DONE;
`endif
            end
`ifdef CHECKSUM_EN
            S_CHK_LO:   if (w_xfer) w_state_nxt = S_CHK_HI;
            S_CHK_HI:   if (w_xfer) w_state_nxt = S_DONE;
`endif
            S_DONE:     if (w_start) w_state_nxt = S_RECV_LO;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_nxt_rdy = (w_state_nxt == S_RECV_LO) || (w_state_nxt == S_RECV_HI);
`ifdef CHECKSUM_EN
        if (w_state_nxt == S_CHK_LO || w_state_nxt == S_CHK_HI) w_nxt_rdy = 1'b1;
`endif
    end

    // Status outputs are decoded from the next state so they flip together with r_state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_ready <= 1'b0;
            r_writing    <= 1'b0;
            r_we_n       <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_we_cnt     <= '0;
        end else begin
            r_byte_ready <= w_nxt_rdy;
            r_writing    <= (w_state_nxt == S_WR_SETUP) || (w_state_nxt == S_WR_PULSE) ||
                            (w_state_nxt == S_WR_HOLD);
            r_we_n       <= (w_state_nxt != S_WR_PULSE);
            r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            if (w_start) begin
                r_addr <= '0;
                r_done <= 1'b0;
            end
            if (r_state == S_RECV_LO && w_xfer) r_data[7:0]            <= bus.i_byte;
            if (r_state == S_RECV_HI && w_xfer) r_data[DATA_WIDTH-1:8] <= bus.i_byte;
            if (r_state == S_WR_SETUP)      r_we_cnt <= '0;
            else if (r_state == S_WR_PULSE) r_we_cnt <= r_we_cnt + CNT_W'(1);
            if (r_state == S_WR_HOLD && r_addr != LAST_ADDR) r_addr <= r_addr + ADDR_WIDTH'(1);
            if (w_state_nxt == S_DONE && r_state != S_DONE) r_done <= 1'b1;
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum    <= '0;
            r_chk_lo <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_start) begin
                r_sum   <= '0;
                r_error <= 1'b0;
            end
            if (r_state == S_WR_HOLD)            r_sum    <= r_sum + r_data;
            if (r_state == S_CHK_LO && w_xfer)   r_chk_lo <= bus.i_byte;
            if (r_state == S_CHK_HI && w_xfer)   r_error  <= ({bus.i_byte, r_chk_lo} != r_sum);
        end
    end
    assign o_error = r_error;
`else
    assign o_error = 1'b0;
`endif

    assign bus.o_byte_ready   = r_byte_ready;
    assign bus.o_sram_writing = r_writing;
    assign bus.o_sram_we_n    = r_we_n;
    assign bus.o_sram_addr    = r_addr;
    assign bus.o_sram_data    = r_data;
    assign o_busy             = r_busy;
    assign o_done             = r_done;
endmodule
